// File: rtl/apb_mem_bridge.sv
// Bridges single RV32I load/store requests from the core FSM onto an APB completer.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e      state_q, state_d;
  logic        req, req_conflict, req_legal;
  logic        size_ok, aligned;
  logic [3:0]  strb_req;
  logic [31:0] wdata_req;
  logic        timeout;

  logic [31:0] paddr_q, pwdata_q, rdata_q, rdata_ext;
  logic [3:0]  pstrb_q;
  logic        pwrite_q, done_q, err_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req          = mem_read_en ^ mem_write_en;
  assign req_conflict = mem_read_en & mem_write_en;
  assign req_legal    = req & size_ok & aligned;

  // Decode size, alignment, strobes and lane-replicated store data of the incoming request.
  always_comb begin
    size_ok   = 1'b0;
    aligned   = 1'b0;
    strb_req  = 4'b0000;
    wdata_req = wdata;
    case (funct3)
      3'b000: begin
        size_ok   = 1'b1;
        aligned   = 1'b1;
        strb_req  = 4'b0001 << addr[1:0];
        wdata_req = {4{wdata[7:0]}};
      end
      3'b001: begin
        size_ok   = 1'b1;
        aligned   = ~addr[0];
        strb_req  = 4'b0011 << addr[1:0];
        wdata_req = {2{wdata[15:0]}};
      end
      3'b010: begin
        size_ok  = 1'b1;
        aligned  = (addr[1:0] == 2'b00);
        strb_req = 4'b1111;
      end
      3'b100: begin
        size_ok = mem_read_en;
        aligned = 1'b1;
      end
      3'b101: begin
        size_ok = mem_read_en;
        aligned = ~addr[0];
      end
      default: ;
    endcase
    if (!mem_write_en) strb_req = 4'b0000;
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != StAccess) begin
      cnt_q <= '0;
    end else if (!pready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StAccess) && !pready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  // The parameter only matters when the timeout is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_legal) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timeout) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    psel    = (state_q != StIdle);
    penable = (state_q == StAccess);
    paddr   = paddr_q;
    pwdata  = pwdata_q;
    pstrb   = pstrb_q;
    pwrite  = pwrite_q;
    rdata   = rdata_q;
    done    = done_q;
    err     = err_q;
  end

  // Load data extraction from the lane selected by the latched byte offset.
  always_comb begin
    lane_b = prdata[7:0];
    case (off_q)
      2'd1:    lane_b = prdata[15:8];
      2'd2:    lane_b = prdata[23:16];
      2'd3:    lane_b = prdata[31:24];
      default: lane_b = prdata[7:0];
    endcase
    lane_h = off_q[1] ? prdata[31:16] : prdata[15:0];
    case (funct3_q)
      3'b000:  rdata_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  rdata_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  rdata_ext = {24'd0, lane_b};
      3'b101:  rdata_ext = {16'd0, lane_h};
      default: rdata_ext = prdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == StIdle) begin
        if (req_conflict || (req && !req_legal)) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end else if (req_legal) begin
          paddr_q  <= {addr[31:2], 2'b00};
          pwdata_q <= wdata_req;
          pstrb_q  <= strb_req;
          pwrite_q <= mem_write_en;
          funct3_q <= funct3;
          off_q    <= addr[1:0];
        end
      end else if (state_q == StAccess && (pready || timeout)) begin
        done_q <= 1'b1;
        err_q  <= pready ? pslverr : 1'b1;
        if (pready && !pslverr && !pwrite_q) rdata_q <= rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench for apb_mem_bridge: directed scenarios then random transfers
// checked against an arithmetic model of the access rules.
module tb_apb_mem_bridge;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rdata_model;

  apb_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .wdata        (wdata),
    .funct3       (funct3),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .pstrb        (pstrb),
    .pready       (pready),
    .pslverr      (pslverr),
    .prdata       (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access rules from the RV32I encoding: size, legality, strobes, store data, load result.
  function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] prd, output bit legal,
                                output logic [3:0] strb, output logic [31:0] pwd,
                                output logic [31:0] ld);
    int          nbytes;
    int          off;
    logic [3:0]  s;
    logic [31:0] mask;
    logic [31:0] v;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    off    = int'(a[1:0]);
    legal  = 1'b0;
    strb   = 4'd0;
    pwd    = wd;
    ld     = 32'd0;
    if (nbytes == 0) return;
    legal = (rd != wr) && !(f3[2] && (wr || nbytes == 4)) && ((off % nbytes) == 0);
    s     = 4'((32'd1 << nbytes) - 32'd1);
    strb  = wr ? (s << off) : 4'd0;
    mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (nbytes == 1) pwd = (wd & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) pwd = (wd & 32'hFFFF) * 32'h0001_0001;
    v = (prd >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
    ld = v;
  endfunction

  // One request from pulse to completion; noise injects a request while busy.
  task automatic xfer(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] prd, input int waits,
                      input bit slverr, input bit noise);
    bit          legal;
    logic [3:0]  strb;
    logic [31:0] pwd, ld, exp_paddr;
    model(rd, wr, f3, a, wd, prd, legal, strb, pwd, ld);
    exp_paddr    = a & 32'hFFFF_FFFC;
    mem_read_en  = rd;
    mem_write_en = wr;
    addr         = a;
    wdata        = wd;
    funct3       = f3;
    step();
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (!legal) begin
      check_b("rej_done", done, 1'b1);
      check_b("rej_err", err, 1'b1);
      check_b("rej_psel", psel, 1'b0);
      check_b("rej_busy", busy, 1'b0);
      check("rej_rdata", rdata, rdata_model);
      step();
      check_b("rej_done_pulse", done, 1'b0);
      check_b("rej_psel_after", psel, 1'b0);
      return;
    end
    check_b("setup_psel", psel, 1'b1);
    check_b("setup_penable", penable, 1'b0);
    check_b("setup_done", done, 1'b0);
    check("setup_paddr", paddr, exp_paddr);
    check_b("setup_pwrite", pwrite, wr);
    check("setup_pstrb", {28'd0, pstrb}, {28'd0, strb});
    if (wr) check("setup_pwdata", pwdata, pwd);
    step();
    for (int w = 0; w <= waits; w++) begin
      check_b("acc_psel", psel, 1'b1);
      check_b("acc_penable", penable, 1'b1);
      check_b("acc_done", done, 1'b0);
      check("acc_paddr", paddr, exp_paddr);
      check("acc_pstrb", {28'd0, pstrb}, {28'd0, strb});
      if (wr) check("acc_pwdata", pwdata, pwd);
      if (noise && w == 0) begin
        mem_read_en = 1'b1;
        addr        = ~a;
        funct3      = ~f3;
      end
      pready  = (w == waits);
      pslverr = slverr && (w == waits);
      prdata  = prd;
      step();
      mem_read_en = 1'b0;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
    if (rd && !slverr) rdata_model = ld;
    check_b("cpl_done", done, 1'b1);
    check_b("cpl_err", err, slverr);
    check_b("cpl_psel", psel, 1'b0);
    check_b("cpl_penable", penable, 1'b0);
    check_b("cpl_busy", busy, 1'b0);
    check("cpl_rdata", rdata, rdata_model);
    step();
    check_b("cpl_done_pulse", done, 1'b0);
    check_b("cpl_err_pulse", err, 1'b0);
    check_b("cpl_idle_psel", psel, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    addr         = '0;
    wdata        = '0;
    funct3       = '0;
    pready       = 1'b0;
    pslverr      = 1'b0;
    prdata       = '0;
    rdata_model  = '0;
    step();
    step();
    check("rst_rdata", rdata, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pstrb", {28'd0, pstrb}, 32'd0);
    check_b("rst_psel", psel, 1'b0);
    check_b("rst_penable", penable, 1'b0);
    check_b("rst_pwrite", pwrite, 1'b0);
    check_b("rst_done", done, 1'b0);
    check_b("rst_err", err, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // Directed scenarios
    xfer(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    check("lw_value", rdata, 32'hDEADBEEF);
    xfer(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0, 0);
    check("lb_value", rdata, 32'hFFFFFF80);
    xfer(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 0);
    check("lbu_value", rdata, 32'h00000080);
    xfer(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2, 0, 0);
    check("lhu_value", rdata, 32'h00008011);
    xfer(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 1);
    xfer(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    xfer(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    xfer(0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    xfer(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 1, 0);
    xfer(1, 0, 3'b010, 32'h300, 32'h0, 32'h55AA1234, 0, 1, 0);
    xfer(1, 0, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 1, 0, 1);

    // Reset while in ACCESS discards the transfer, no completion pulse
    mem_read_en = 1'b1;
    addr        = 32'h400;
    funct3      = 3'b010;
    step();
    mem_read_en = 1'b0;
    step();
    check_b("abort_pre_penable", penable, 1'b1);
    rst = 1'b1;
    step();
    rst         = 1'b0;
    rdata_model = 32'd0;
    check_b("abort_psel", psel, 1'b0);
    check_b("abort_penable", penable, 1'b0);
    check_b("abort_done", done, 1'b0);
    check_b("abort_busy", busy, 1'b0);
    check("abort_rdata", rdata, rdata_model);
    step();
    check_b("abort_no_done", done, 1'b0);

    // ACCESS held with pready low
    mem_read_en = 1'b1;
    addr        = 32'h500;
    funct3      = 3'b010;
    step();
    mem_read_en = 1'b0;
    step();
`ifdef APB_TIMEOUT_EN
    for (int c = 0; c < int'(TO); c++) begin
      check_b("to_wait_penable", penable, 1'b1);
      check_b("to_wait_done", done, 1'b0);
      step();
    end
    check_b("to_done", done, 1'b1);
    check_b("to_err", err, 1'b1);
    check_b("to_psel", psel, 1'b0);
    check_b("to_busy", busy, 1'b0);
    check("to_rdata", rdata, rdata_model);
    step();
    check_b("to_done_pulse", done, 1'b0);
`else
    for (int c = 0; c < 40; c++) begin
      check_b("wait_penable", penable, 1'b1);
      check_b("wait_done", done, 1'b0);
      step();
    end
    pready = 1'b1;
    prdata = 32'h76543210;
    step();
    pready      = 1'b0;
    rdata_model = 32'h76543210;
    check_b("wait_cpl_done", done, 1'b1);
    check_b("wait_cpl_err", err, 1'b0);
    check("wait_cpl_rdata", rdata, rdata_model);
    step();
`endif

    // Random transfers against the model
    for (int t = 0; t < 60; t++) begin
      int          r;
      bit          rd, wr;
      logic [2:0]  f3;
      r  = int'($urandom_range(0, 9));
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      f3 = 3'($urandom_range(0, 7));
      xfer(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
